// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared VRAM port widths, clog2 helper and client id type
package vram_pkg;

    localparam int VRAM_ADDR_W  = 15;
    localparam int VRAM_DATA_W  = 32;
    localparam int VRAM_MAX_REQ = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Wide enough for any supported client count; narrower ids widen into it.
    typedef logic [clog2(VRAM_MAX_REQ)-1:0] client_id_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first eligible index at or after rr_ptr, wrapping
module rr_pick
    import vram_pkg::*;
#(
    parameter int N   = 3,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   eligible_i,
    input  logic [IDW-1:0] rr_ptr_i,
    output logic [IDW-1:0] winner_o,
    output logic           any_o
);

    logic           hit_hi;
    logic [IDW-1:0] win_hi;
    logic [IDW-1:0] win_lo;
    client_id_t     ptr_w;

    // Descending scan so the last hit kept is the lowest index in each half.
    always_comb begin
        hit_hi = 1'b0;
        win_hi = '0;
        win_lo = '0;
        ptr_w  = client_id_t'(rr_ptr_i);
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                win_lo = IDW'(i);
                if (client_id_t'(i) >= ptr_w) begin
                    win_hi = IDW'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        winner_o = hit_hi ? win_hi : win_lo;
        any_o    = |eligible_i;
    end

endmodule

// File: rtl/vram_rd_arbiter.sv
// rtl/vram_rd_arbiter.sv - round-robin VRAM read arbiter; VRAM_RD_ARB_HOLD_EN adds per-client read-data hold regs
module vram_rd_arbiter
    import vram_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = VRAM_ADDR_W,
    parameter int DATA_W  = VRAM_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_strobe,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ*DATA_W-1:0] req_rddata,
    output logic                      mem_strobe,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_rddata
);

    localparam int IDW = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);

    logic               iss_valid_q, iss_valid_d;
    logic [IDW-1:0]     iss_id_q, iss_id_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] done_mask;
    logic [NUM_REQ-1:0] eligible;
    logic [IDW-1:0]     winner;
    logic               any;

    // An ack with nothing in flight (e.g. straddling a reset) is dropped here.
    always_comb begin
        done_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mem_ack && iss_valid_q && (iss_id_q == IDW'(i))) begin
                done_mask[i] = 1'b1;
            end
        end
    end

    // Masking the completing client stops a re-issue of the read just served.
    assign eligible = req_strobe & ~done_mask;
    assign req_ack  = done_mask;

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_rr_pick (
        .eligible_i (eligible),
        .rr_ptr_i   (rr_ptr_q),
        .winner_o   (winner),
        .any_o      (any)
    );

    always_comb begin
        mem_strobe = any & rst_n;
        mem_addr   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mem_strobe && (winner == IDW'(i))) begin
                mem_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Pointer only moves on a served access, so a pre-empted client wins again.
    always_comb begin
        iss_valid_d = mem_strobe;
        iss_id_d    = winner;
        rr_ptr_d    = rr_ptr_q;
        if (|done_mask) begin
            rr_ptr_d = (iss_id_q == IDW'(NUM_REQ - 1)) ? '0 : iss_id_q + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q <= 1'b0;
            iss_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_id_q    <= iss_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

`ifdef VRAM_RD_ARB_HOLD_EN
    logic [NUM_REQ-1:0][DATA_W-1:0] hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ack[i]) begin
                    hold_q[i] <= mem_rddata;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rddata[i*DATA_W +: DATA_W] = req_ack[i] ? mem_rddata : hold_q[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rddata[i*DATA_W +: DATA_W] = mem_rddata;
        end
    end
`endif

endmodule

// File: tb/tb_vram_rd_arbiter.sv
// tb/tb_vram_rd_arbiter.sv - table-driven bench with read-data scoreboard for vram_rd_arbiter
module tb_vram_rd_arbiter;

    localparam int N  = 3;
    localparam int AW = 15;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_strobe;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ack;
    logic [N*DW-1:0] req_rddata;
    logic            mem_strobe;
    logic [AW-1:0]   mem_addr;
    logic            mem_ack;
    logic [DW-1:0]   mem_rddata;

    vram_rd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_strobe (req_strobe),
        .req_addr   (req_addr),
        .req_ack    (req_ack),
        .req_rddata (req_rddata),
        .mem_strobe (mem_strobe),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rddata (mem_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] strb;
        bit           pre;
        bit           exp_s;
        int           exp_w;
        logic [N-1:0] exp_ack;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] data;
    } sb_t;

    vec_t          tbl[$];
    sb_t           sb[$];
    logic [AW-1:0] cur_addr[N];
    int            n_vec = 0;
    int            n_err = 0;

    function automatic vec_t mk(logic [N-1:0] s, bit p, bit es, int ew, logic [N-1:0] ea);
        vec_t v;
        v.strb = s; v.pre = p; v.exp_s = es; v.exp_w = ew; v.exp_ack = ea;
        return v;
    endfunction

    function automatic logic [31:0] mem_data(logic [AW-1:0] a);
        case (a)
            15'h0123: return 32'hDEADBEEF;
            15'h0555: return 32'hA5A5A5A5;
            15'h0000: return 32'h00000000;
            default:  return 32'h5A000000 | {17'h0, a};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, memory model answers next negedge.
    task automatic apply(input vec_t v);
        logic         nxt_ack;
        logic [31:0]  nxt_data;
        logic [N-1:0] acked;
        sb_t          e;
        req_strobe = v.strb;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = cur_addr[i];
        #1;
        chk("mem_strobe", {63'h0, mem_strobe}, {63'h0, v.exp_s});
        if (v.exp_s) chk("mem_addr", {49'h0, mem_addr}, {49'h0, cur_addr[v.exp_w]});
        chk("req_ack", {61'h0, req_ack}, {61'h0, v.exp_ack});
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_ack", 64'(i), 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("sb_id", 64'(i), 64'(e.id));
                    chk("sb_data", {32'h0, req_rddata[i*DW +: DW]}, {32'h0, e.data});
                end
            end
        end
        if (v.exp_s && !v.pre) begin
            e.id = v.exp_w;
            e.data = mem_data(cur_addr[v.exp_w]);
            sb.push_back(e);
        end
        nxt_ack  = mem_strobe && !v.pre;
        nxt_data = mem_data(mem_addr);
        acked    = req_ack;
        @(posedge clk);
        @(negedge clk);
        mem_ack    = nxt_ack;
        mem_rddata = nxt_ack ? nxt_data : $urandom;
        for (int i = 0; i < N; i++) if (acked[i]) cur_addr[i] = cur_addr[i] + 15'h10;
    endtask

    task automatic run_table();
        for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);
        tbl.delete();
    endtask

    initial begin
        rst_n = 1'b0; req_strobe = '0; req_addr = '0; mem_ack = 1'b0; mem_rddata = '0;
        cur_addr[0] = 15'h0010; cur_addr[1] = 15'h0020; cur_addr[2] = 15'h0030;
        #1;
        chk("rst_mem_strobe", {63'h0, mem_strobe}, 64'h0);
        chk("rst_req_ack", {61'h0, req_ack}, 64'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // All three clients continuously: one grant per cycle in 0,1,2 order.
        tbl.push_back(mk(3'b111, 0, 1, 0, 3'b000));
        tbl.push_back(mk(3'b111, 0, 1, 1, 3'b001));
        tbl.push_back(mk(3'b111, 0, 1, 2, 3'b010));
        tbl.push_back(mk(3'b111, 0, 1, 0, 3'b100));
        tbl.push_back(mk(3'b111, 0, 1, 1, 3'b001));
        tbl.push_back(mk(3'b111, 0, 1, 2, 3'b010));
        tbl.push_back(mk(3'b100, 0, 0, 0, 3'b100));
        tbl.push_back(mk(3'b000, 0, 0, 0, 3'b000));
        run_table();

        // Single client 1 at 0x0123, acked with 0xDEADBEEF one cycle later.
        cur_addr[1] = 15'h0123;
        tbl.push_back(mk(3'b010, 0, 1, 1, 3'b000));
        tbl.push_back(mk(3'b010, 0, 0, 0, 3'b010));
        tbl.push_back(mk(3'b000, 0, 0, 0, 3'b000));
        run_table();

        // Client 2 masked in its ack cycle, new address issued the cycle after.
        cur_addr[2] = 15'h0200;
        tbl.push_back(mk(3'b100, 0, 1, 2, 3'b000));
        tbl.push_back(mk(3'b100, 0, 0, 0, 3'b100));
        tbl.push_back(mk(3'b100, 0, 1, 2, 3'b000));
        tbl.push_back(mk(3'b100, 0, 0, 0, 3'b100));
        tbl.push_back(mk(3'b000, 0, 0, 0, 3'b000));
        run_table();

        // Client 0 pre-empted three times, then served; pointer lands on 1.
        cur_addr[0] = 15'h0300; cur_addr[1] = 15'h0310;
        tbl.push_back(mk(3'b001, 1, 1, 0, 3'b000));
        tbl.push_back(mk(3'b001, 1, 1, 0, 3'b000));
        tbl.push_back(mk(3'b001, 1, 1, 0, 3'b000));
        tbl.push_back(mk(3'b001, 0, 1, 0, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 0, 3'b001));
        tbl.push_back(mk(3'b000, 0, 0, 0, 3'b000));
        tbl.push_back(mk(3'b011, 0, 1, 1, 3'b000));
        tbl.push_back(mk(3'b011, 0, 1, 0, 3'b010));
        tbl.push_back(mk(3'b011, 0, 1, 1, 3'b001));
        tbl.push_back(mk(3'b010, 0, 0, 0, 3'b010));
        tbl.push_back(mk(3'b000, 0, 0, 0, 3'b000));
        run_table();

        // Reset for two cycles with client 1 in flight; stale ack after release.
        apply(mk(3'b010, 0, 1, 1, 3'b000));
        rst_n = 1'b0;
        #1;
        chk("inrst_mem_strobe_0", {63'h0, mem_strobe}, 64'h0);
        chk("inrst_req_ack_0", {61'h0, req_ack}, 64'h0);
        @(posedge clk); @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("inrst_mem_strobe_1", {63'h0, mem_strobe}, 64'h0);
        chk("inrst_req_ack_1", {61'h0, req_ack}, 64'h0);
        @(posedge clk); @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rddata = $urandom;
        apply(mk(3'b111, 0, 1, 0, 3'b000));
        apply(mk(3'b111, 0, 1, 1, 3'b001));
        apply(mk(3'b010, 0, 0, 0, 3'b010));
        apply(mk(3'b000, 0, 0, 0, 3'b000));

        // Client 1 gets 0xA5A5A5A5, then client 0 gets 0x0.
        cur_addr[1] = 15'h0555; cur_addr[0] = 15'h0000;
        tbl.push_back(mk(3'b010, 0, 1, 1, 3'b000));
        tbl.push_back(mk(3'b010, 0, 0, 0, 3'b010));
        tbl.push_back(mk(3'b001, 0, 1, 0, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 0, 3'b001));
        tbl.push_back(mk(3'b000, 0, 0, 0, 3'b000));
        run_table();
`ifdef VRAM_RD_ARB_HOLD_EN
        #1;
        chk("hold_slice1", {32'h0, req_rddata[1*DW +: DW]}, 64'hA5A5A5A5);
        chk("hold_slice0", {32'h0, req_rddata[0*DW +: DW]}, 64'h0);
`endif

        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
